// File: rtl/conv_stream_controller.sv
// conv_stream_controller: sequences coefficient load and pixel streaming for the convolution datapath
module conv_stream_controller #(
  parameter int IMG_WIDTH     = 8,
  parameter int IMG_HEIGHT    = 6,
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_HEIGHT = 3,
  parameter int NUM_COEF      = 9,
  parameter int LATENCY       = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  input  logic        m_axis_tready,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        conv_we,
  output logic [13:0] conv_wr_addr,
  output logic        conv_ready,
  output logic        conv_eol,
  output logic        busy,
  output logic        done,
  output logic        err_tlast,
  output logic        err_overrun
);
  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int RW = $clog2(IMG_HEIGHT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [13:0] coef_idx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [LATENCY-1:0] vpipe, lpipe, vpipe_nxt, lpipe_nxt;
  logic acc, eol_pos, last_pos, res_beat;
  always_comb begin
    s_axis_tready = (state == LOAD) | ((state == STREAM) & m_axis_tready);
    acc = s_axis_tvalid & s_axis_tready;
    eol_pos = col == CW'(IMG_WIDTH - 1);
    last_pos = eol_pos & (row == RW'(IMG_HEIGHT - 1));
    conv_we = acc & (state == LOAD);
    conv_wr_addr = conv_we ? coef_idx : '0;
    conv_ready = acc & (state == STREAM);
    conv_eol = conv_ready & eol_pos;
    res_beat = conv_ready & (row >= RW'(KERNEL_HEIGHT - 1)) & (col >= CW'(KERNEL_WIDTH - 1));
    // non-result cycles shift zeros in, so DRAIN ends once the next pipe is empty
    vpipe_nxt = (vpipe << 1) | LATENCY'(res_beat);
    lpipe_nxt = (lpipe << 1) | LATENCY'(res_beat & last_pos);
    m_axis_tvalid = vpipe[LATENCY-1];
    m_axis_tlast = lpipe[LATENCY-1] & vpipe[LATENCY-1];
    busy = state != IDLE;
    done = state == DONE;
    state_nxt = ((state == IDLE) & start) ? LOAD :
                (conv_we & (coef_idx == 14'(NUM_COEF - 1))) ? STREAM :
                (conv_ready & last_pos) ? DRAIN :
                ((state == DRAIN) & ~|vpipe_nxt) ? DONE :
                (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      coef_idx <= '0;
      col <= '0;
      row <= '0;
      vpipe <= '0;
      lpipe <= '0;
      err_tlast <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      vpipe <= vpipe_nxt;
      lpipe <= lpipe_nxt;
      if ((state == IDLE) & start) begin
        coef_idx <= '0;
        col <= '0;
        row <= '0;
        err_tlast <= 1'b0;
        err_overrun <= 1'b0;
      end else begin
        if (conv_we) coef_idx <= coef_idx + 14'd1;
        if (conv_ready) begin
          col <= eol_pos ? '0 : col + 1'b1;
          row <= eol_pos ? row + 1'b1 : row;
        end
        if (conv_ready & (s_axis_tlast != eol_pos)) err_tlast <= 1'b1;
        if (m_axis_tvalid & ~m_axis_tready) err_overrun <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_conv_stream_controller.sv
// tb_conv_stream_controller: randomized scoreboard bench for conv_stream_controller
module tb_conv_stream_controller;
  localparam int W = 8, H = 6, KW = 3, KH = 3, NC = 9, L = 4;
  logic clk = 0, resetn, start, s_axis_tvalid, s_axis_tlast, s_axis_tready, m_axis_tready;
  logic m_axis_tvalid, m_axis_tlast, conv_we, conv_ready, conv_eol, busy, done, err_tlast, err_overrun;
  logic [13:0] conv_wr_addr;
  int cyc = 0, total = 0, bad = 0;
  int phase = 0, ncoef = 0, npix = 0, post = 0;
  logic exp_tl = 0, exp_ov = 0;
  typedef struct {logic tr, we; logic [13:0] ad; logic cr, eol, busy, clr, tle;} rec_t;
  typedef struct {int c; logic last;} res_t;
  rec_t sq[$];
  res_t rq[$];
  int dq[$];

  conv_stream_controller dut (
    .clk(clk), .resetn(resetn), .start(start),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .conv_we(conv_we), .conv_wr_addr(conv_wr_addr), .conv_ready(conv_ready), .conv_eol(conv_eol),
    .busy(busy), .done(done), .err_tlast(err_tlast), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", n, a, e, cyc);
    end
  endtask

  // one cycle of stimulus; the expected response follows from beat counts and the frame timing rules
  task automatic step(input logic st, input logic tv, input logic tl, input logic mr, input logic rn);
    rec_t r;
    res_t x;
    logic acc;
    int pr, pc;
    start = st; s_axis_tvalid = tv; s_axis_tlast = tl; m_axis_tready = mr; resetn = rn;
    pr = npix / W;
    pc = npix % W;
    r.tr = phase == 1 ? 1'b1 : phase == 2 ? mr : 1'b0;
    acc = tv & r.tr;
    r.we = acc & (phase == 1);
    r.ad = r.we ? 14'(ncoef) : 14'd0;
    r.cr = acc & (phase == 2);
    r.eol = r.cr & (pc == W - 1);
    r.tle = r.cr & (tl != (pc == W - 1));
    r.busy = phase != 0;
    r.clr = !rn | ((phase == 0) & st);
    if (r.cr && pr >= KH - 1 && pc >= KW - 1) begin
      x.c = cyc + L;
      x.last = npix == W * H - 1;
      rq.push_back(x);
    end
    sq.push_back(r);
    if (!rn) begin
      phase = 0;
      while (rq.size() > 0 && rq[$].c > cyc) void'(rq.pop_back());
      while (dq.size() > 0 && dq[$] > cyc) void'(dq.pop_back());
    end else if (phase == 0) begin
      if (st) begin phase = 1; ncoef = 0; npix = 0; end
    end else if (phase == 1) begin
      if (acc) ncoef++;
      if (ncoef == NC) phase = 2;
    end else if (phase == 2) begin
      if (acc) npix++;
      if (npix == W * H) begin phase = 3; post = L + 1; dq.push_back(cyc + L + 1); end
    end else begin
      post--;
      if (post == 0) phase = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // mode 0: clean frame; mode 1: tlast error + 5-cycle sink drop; mode 2: fully random
  task automatic frame(input int mode, input int abort_at);
    int g = 0, drop = 0, guard = 0;
    logic tv, tl, mr;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    while (phase == 1 && guard < 2000) begin
      guard++;
      tv = mode == 0 ? !(ncoef == 4 && g < 2) : ($urandom_range(0, 3) != 0);
      if (mode == 0 && ncoef == 4 && g < 2) g++;
      step(1'b0, tv, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    end
    while (phase == 2 && guard < 2000) begin
      guard++;
      if (abort_at >= 0 && npix == abort_at) begin
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        break;
      end
      tl = (npix % W == W - 1) || (mode == 1 && npix == W + 5);
      if (mode == 2) tl = tl ^ ($urandom_range(0, 15) == 0);
      mr = 1'b1;
      if (mode == 1 && npix == 2 * W + 3 && drop < 5) begin mr = 1'b0; drop++; end
      if (mode == 2) mr = $urandom_range(0, 4) != 0;
      tv = mode == 2 ? ($urandom_range(0, 3) != 0) : 1'b1;
      step(1'b0, tv, tl, mr, 1'b1);
    end
    while (phase == 3 && guard < 2000) begin
      guard++;
      step(1'b0, 1'b0, 1'b0, mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1, 1'b1);
    end
    chk("frame_bound", 32'(guard < 2000), 32'd1);
  endtask

  always @(negedge clk) begin
    if (sq.size() > 0) begin
      rec_t r;
      logic ev, el, ed;
      r = sq.pop_front();
      ev = rq.size() > 0 && rq[0].c == cyc;
      el = ev && rq[0].last;
      if (ev) void'(rq.pop_front());
      ed = dq.size() > 0 && dq[0] == cyc;
      if (ed) void'(dq.pop_front());
      chk("s_tready", 32'(s_axis_tready), 32'(r.tr));
      chk("conv_we", 32'(conv_we), 32'(r.we));
      chk("wr_addr", 32'(conv_wr_addr), 32'(r.ad));
      chk("conv_ready", 32'(conv_ready), 32'(r.cr));
      chk("conv_eol", 32'(conv_eol), 32'(r.eol));
      chk("busy", 32'(busy), 32'(r.busy));
      chk("m_tvalid", 32'(m_axis_tvalid), 32'(ev));
      chk("m_tlast", 32'(m_axis_tlast), 32'(el));
      chk("done", 32'(done), 32'(ed));
      chk("err_tlast", 32'(err_tlast), 32'(exp_tl));
      chk("err_overrun", 32'(err_overrun), 32'(exp_ov));
      if (r.clr) begin
        exp_tl = 1'b0;
        exp_ov = 1'b0;
      end else begin
        if (r.tle) exp_tl = 1'b1;
        if (ev && !m_axis_tready) exp_ov = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    resetn = 0; start = 1; s_axis_tvalid = 0; s_axis_tlast = 0; m_axis_tready = 1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    frame(0, -1);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    frame(1, -1);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    frame(0, 21);
    repeat (6) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    frame(0, -1);
    repeat (4) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      frame(2, -1);
    end
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    chk("results_outstanding", rq.size(), 0);
    chk("done_outstanding", dq.size(), 0);
    chk("records_outstanding", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_stream_controller.md
# conv_stream_controller

Sequencing controller for the multi-dimension convolution datapath. It runs one frame: first it loads kernel coefficients, then it streams pixels. It converts the upstream AXI-Stream handshake into the datapath's `we`/`wr_addr`/`ready`/`eol` strobes, and it generates the result-side `tvalid`/`tlast` from a fixed pipeline latency. Pixel and coefficient data are wired directly from the source to the datapath; this block carries only control.

## Interface
- `IMG_WIDTH`, 8: pixels per line (≥ `KERNEL_WIDTH`).
- `IMG_HEIGHT`, 6: lines per frame (≥ `KERNEL_HEIGHT`).
- `KERNEL_WIDTH`, 3: kernel columns.
- `KERNEL_HEIGHT`, 3: kernel rows.
- `NUM_COEF`, 9: coefficient beats per load (1..16384).
- `LATENCY`, 4: datapath cycles from the `conv_ready` strobe to a valid result (≥ 1).
- `clk` in 1: clock.
- `resetn` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle frame start; honoured only in IDLE.
- `s_axis_tvalid` in 1: source beat valid (coefficient or pixel).
- `s_axis_tlast` in 1: source end-of-line marker (STREAM only).
- `s_axis_tready` out 1: source beat accepted.
- `m_axis_tready` in 1: sink ready for results.
- `m_axis_tvalid` out 1: result valid on the datapath output.
- `m_axis_tlast` out 1: last result of the frame.
- `conv_we` out 1: coefficient write strobe to the datapath.
- `conv_wr_addr` out 14: coefficient write address.
- `conv_ready` out 1: pixel-advance strobe to the datapath.
- `conv_eol` out 1: end-of-line strobe to the datapath.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle frame-complete pulse.
- `err_tlast` out 1: sticky; set on a `s_axis_tlast` mismatch, cleared on an accepted `start`.
- `err_overrun` out 1: sticky; set when a result emerges while `m_axis_tready` is 0, cleared on an accepted `start`.

## Operation
- States: IDLE, LOAD, STREAM, DRAIN, DONE.
- Reset (`resetn` = 0 at a clock edge), from any state:
  - State goes to IDLE.
  - All counters, the valid pipe, and all outputs go to 0.
  - Reset mid-frame abandons the frame and does not pulse `done`.
- Beat acceptance: `acc = s_axis_tvalid & s_axis_tready`.
- IDLE:
  - `s_axis_tready` = 0.
  - `start` moves to LOAD, clears both error flags and zeroes the counters.
- LOAD:
  - `s_axis_tready` = 1.
  - Each `acc` drives `conv_we` = 1, `conv_wr_addr` = coefficient index (0..`NUM_COEF`-1), then increments the index.
  - The `acc` with index `NUM_COEF`-1 moves to STREAM.
  - `s_axis_tlast` is ignored in LOAD.
- STREAM:
  - `s_axis_tready` = `m_axis_tready`. The datapath cannot stall, so input is throttled by the sink.
  - Each `acc` asserts `conv_ready`, then advances `col`. `col` wraps at `IMG_WIDTH`-1 to 0 and increments `row`.
  - `conv_eol` = `acc` & (`col` = `IMG_WIDTH`-1).
  - On `acc`, `s_axis_tlast` ≠ (`col` = `IMG_WIDTH`-1) sets `err_tlast`. Counting continues by position, not by tlast.
  - A result-producing beat satisfies `row` ≥ `KERNEL_HEIGHT`-1 and `col` ≥ `KERNEL_WIDTH`-1. It pushes 1 into the `LATENCY`-deep valid shift pipe; every other cycle pushes 0.
  - The last-beat flag is (`row`,`col`) = (`IMG_HEIGHT`-1, `IMG_WIDTH`-1). It travels in a parallel pipe.
  - The `acc` on the last pixel moves to DRAIN.
- DRAIN:
  - `s_axis_tready` = 0.
  - The pipe keeps shifting in zeros.
  - Moves to DONE when the pipe holds no 1s, i.e. `LATENCY` cycles after the last beat.
- DONE:
  - `done` = 1 for one cycle.
  - Next state is IDLE.
- Pipe output:
  - `m_axis_tvalid` = pipe stage `LATENCY`-1.
  - `m_axis_tlast` = last-flag stage `LATENCY`-1 & `m_axis_tvalid`.
  - `m_axis_tvalid` & !`m_axis_tready` sets `err_overrun`. The result is not held.
- Result count per frame: (`IMG_WIDTH`-`KERNEL_WIDTH`+1)·(`IMG_HEIGHT`-`KERNEL_HEIGHT`+1).
- `start` outside IDLE is ignored.
- `start` in the same cycle as `resetn` = 0: reset wins.

## Timing
- `s_axis_tready` is combinational from state and `m_axis_tready`. Timing-critical: it is a pass-through.
- `conv_we`, `conv_wr_addr`, `conv_ready` and `conv_eol` are combinational from `acc`, state and counters, so they align with the `s_axis_tdata` the datapath sees in the same cycle.
- All state, counters, pipe and sticky flags are registered.
- The result for a beat accepted at cycle t has `m_axis_tvalid` = 1 at cycle t+`LATENCY`.
- `start` at cycle t gives LOAD at t+1; the first coefficient can be accepted at t+1.
- `done` rises `LATENCY`+1 cycles after the last pixel `acc`: DRAIN lasts `LATENCY` cycles, then DONE lasts one.
- `busy` = 0 exactly in IDLE, so it is 0 in the cycle after `done`.

## Test plan
- Reset: hold `resetn` = 0 for 3 cycles with `start` = 1 -> all outputs 0 and state IDLE; release -> `busy` still 0 until the next `start`.
- Coefficient load: defaults, `start`, 9 beats with a `s_axis_tvalid` gap after beat 4 -> 9 `conv_we` pulses with `conv_wr_addr` 0..8 in order, and no pulse during the gap.
- Full frame: 48 pixels, tvalid always 1, `m_axis_tready` = 1, correct tlast on every 8th beat ->
  - 6 `conv_eol` pulses.
  - 24 `m_axis_tvalid` cycles.
  - The first result 4 cycles after pixel (2,2).
  - One `m_axis_tlast`, aligned with the 24th result.
  - `done` 5 cycles after the 48th beat.
  - Both errors 0.
- Backpressure: drop `m_axis_tready` for 5 cycles mid-line ->
  - `s_axis_tready` is 0 in those cycles and no `conv_ready` pulses.
  - `err_overrun` is set only if an in-flight result emerges during the drop.
  - The total result count is still 24.
- Tlast errors: assert tlast at `col` = 5 of line 1 -> `err_tlast` = 1 and stays set; counting is unchanged (still 6 `conv_eol`). The next `start` clears it.
- Abort: assert `resetn` = 0 in the cycle after pixel 20 -> IDLE, no `done`, no further strobes. A fresh `start` then runs a clean full frame.
